// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if: control and status bundle for prog_clock_divider.
// The sync strobe exists only when PHASE_SYNC_EN is defined.
interface prog_clock_divider_if #(parameter int WIDTH = 17);
    logic             ena;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
`ifdef PHASE_SYNC_EN
    logic             sync;
`endif
    logic             clk_out;
    logic             tick_out;
    logic [WIDTH-1:0] div_active;
    logic             load_pending;
    logic             div_err;
`ifdef PHASE_SYNC_EN
    modport master(output ena, div_in, div_load, sync,
                   input clk_out, tick_out, div_active, load_pending, div_err);
    modport slave(input ena, div_in, div_load, sync,
                  output clk_out, tick_out, div_active, load_pending, div_err);
`else
    modport master(output ena, div_in, div_load,
                   input clk_out, tick_out, div_active, load_pending, div_err);
    modport slave(input ena, div_in, div_load,
                  output clk_out, tick_out, div_active, load_pending, div_err);
`endif
endinterface

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable divider with shadowed divisor, square clk_out and tick strobe.
// Optional phase realignment via the sync strobe when PHASE_SYNC_EN is defined.
module prog_clock_divider #(
    parameter int WIDTH       = 17,
    parameter int DIV_DEFAULT = 10000
) (
    input logic                  clk_in,
    input logic                  res,
    prog_clock_divider_if.slave  bus
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             term;
    logic             load_ok;
    logic             realign;

    assign term    = bus.ena && (cnt_q == act_q - WIDTH'(1));
    assign load_ok = bus.div_load && (bus.div_in >= WIDTH'(2));
`ifdef PHASE_SYNC_EN
    assign realign = bus.sync;
`else
    assign realign = 1'b0;
`endif

    // Pending divisor is consumed at a period boundary (or a realign), before this cycle's load lands.
    always_comb begin
        cnt_d    = realign ? '0 : !bus.ena ? cnt_q : term ? '0 : cnt_q + WIDTH'(1);
        clk_d    = realign ? 1'b0 : term ? ~clk_q : clk_q;
        tick_d   = !realign && term;
        act_d    = ((realign || term) && pend_q) ? shadow_q : act_q;
        pend_d   = load_ok ? 1'b1 : (realign || term) ? 1'b0 : pend_q;
        shadow_d = load_ok ? bus.div_in : shadow_q;
        err_d    = bus.div_load ? !load_ok : err_q;
    end

    always_ff @(posedge clk_in) begin
        if (!res) begin
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            act_q    <= WIDTH'(DIV_DEFAULT);
            shadow_q <= WIDTH'(DIV_DEFAULT);
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            act_q    <= act_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign bus.clk_out      = clk_q;
    assign bus.tick_out     = tick_q;
    assign bus.div_active   = act_q;
    assign bus.load_pending = pend_q;
    assign bus.div_err      = err_q;
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed scenarios plus randomized run against a period-level reference model.
module tb_prog_clock_divider;
    localparam int W = 17;
    logic clk = 1'b0;
    logic res = 1'b1;
    int checks = 0;
    int failures = 0;

    prog_clock_divider_if #(.WIDTH(W)) bus();
    prog_clock_divider #(.WIDTH(W), .DIV_DEFAULT(4)) dut(.clk_in(clk), .res(res), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model tracks enabled cycles into the current period and completed periods since phase origin.
    int          m_el, m_per;
    logic        m_tick, m_pend, m_err;
    logic [W-1:0] m_act, m_sh;

    task automatic adv();
        @(posedge clk);
        if (!res) begin
            m_el = 0; m_per = 0; m_tick = 0; m_act = 4; m_sh = 4; m_pend = 0; m_err = 0;
        end else begin
            m_tick = 0;
`ifdef PHASE_SYNC_EN
            if (bus.sync) begin
                m_el = 0; m_per = 0;
                if (m_pend) begin m_act = m_sh; m_pend = 0; end
            end else
`endif
            if (bus.ena) begin
                m_el++;
                if (m_el == int'(m_act)) begin
                    m_el = 0; m_per++; m_tick = 1;
                    if (m_pend) begin m_act = m_sh; m_pend = 0; end
                end
            end
            if (bus.div_load) begin
                if (bus.div_in >= 2) begin m_sh = bus.div_in; m_pend = 1; m_err = 0; end
                else m_err = 1;
            end
        end
        #1;
        bus.div_load = 1'b0;
`ifdef PHASE_SYNC_EN
        bus.sync = 1'b0;
`endif
    endtask

    task automatic load(input int v);
        bus.div_load = 1'b1;
        bus.div_in = W'(v);
    endtask

    task automatic test_reset();
        res = 1'b0; bus.ena = 1'b0;
        adv();
        res = 1'b1;
        checks++;
        if (bus.tick_out !== 1'b0 || bus.clk_out !== 1'b0 || bus.div_active !== 4 ||
            bus.load_pending !== 1'b0 || bus.div_err !== 1'b0) begin
            failures++;
            $display("FAIL reset tick=%b clk=%b act=%0d pend=%b err=%b expected 0 0 4 0 0",
                     bus.tick_out, bus.clk_out, bus.div_active, bus.load_pending, bus.div_err);
        end
    endtask

    task automatic test_basic();
        test_reset();
        bus.ena = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            adv();
            checks++;
            if (bus.tick_out !== (k % 4 == 0) || bus.clk_out !== ((k / 4) % 2 == 1) || bus.div_active !== 4) begin
                failures++;
                $display("FAIL basic k=%0d tick=%b clk=%b act=%0d expected tick=%b clk=%b act=4",
                         k, bus.tick_out, bus.clk_out, bus.div_active, k % 4 == 0, (k / 4) % 2 == 1);
            end
        end
    endtask

    task automatic test_load();
        test_reset();
        bus.ena = 1'b1;
        adv();
        load(6);
        for (int k = 2; k <= 16; k++) begin
            adv();
            checks++;
            if (bus.tick_out !== (k == 4 || k == 10 || k == 16) || bus.load_pending !== (k < 4) ||
                bus.div_active !== (k >= 4 ? 6 : 4)) begin
                failures++;
                $display("FAIL load k=%0d tick=%b pend=%b act=%0d expected tick=%b pend=%b act=%0d",
                         k, bus.tick_out, bus.load_pending, bus.div_active,
                         k == 4 || k == 10 || k == 16, k < 4, k >= 4 ? 6 : 4);
            end
        end
    endtask

    task automatic test_invalid();
        test_reset();
        bus.ena = 1'b1;
        adv();
        load(1);
        for (int k = 2; k <= 11; k++) begin
            if (k == 4) load(3);
            adv();
            checks++;
            if (bus.div_err !== (k < 4) || bus.load_pending !== (k >= 4 && k < 8) ||
                bus.div_active !== (k >= 8 ? 3 : 4) || bus.tick_out !== (k == 4 || k == 8 || k == 11)) begin
                failures++;
                $display("FAIL invalid k=%0d err=%b pend=%b act=%0d tick=%b expected err=%b pend=%b act=%0d tick=%b",
                         k, bus.div_err, bus.load_pending, bus.div_active, bus.tick_out,
                         k < 4, k >= 4 && k < 8, k >= 8 ? 3 : 4, k == 4 || k == 8 || k == 11);
            end
        end
    endtask

    task automatic test_freeze();
        test_reset();
        bus.ena = 1'b1;
        adv(); adv();
        for (int k = 3; k <= 10; k++) begin
            bus.ena = !(k >= 3 && k <= 7);
            adv();
            checks++;
            if (bus.tick_out !== (k == 9) || bus.clk_out !== (k >= 9)) begin
                failures++;
                $display("FAIL freeze k=%0d tick=%b clk=%b expected tick=%b clk=%b",
                         k, bus.tick_out, bus.clk_out, k == 9, k >= 9);
            end
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        bus.ena = 1'b1;
        load(6); adv();
        load(0); adv();
        adv();
        res = 1'b0;
        adv();
        res = 1'b1;
        checks++;
        if (bus.tick_out !== 1'b0 || bus.clk_out !== 1'b0 || bus.div_active !== 4 ||
            bus.load_pending !== 1'b0 || bus.div_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid tick=%b clk=%b act=%0d pend=%b err=%b expected 0 0 4 0 0",
                     bus.tick_out, bus.clk_out, bus.div_active, bus.load_pending, bus.div_err);
        end
        for (int k = 1; k <= 4; k++) begin
            adv();
            checks++;
            if (bus.tick_out !== (k == 4) || bus.div_active !== 4) begin
                failures++;
                $display("FAIL reset_mid_after k=%0d tick=%b act=%0d expected tick=%b act=4",
                         k, bus.tick_out, bus.div_active, k == 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        bus.ena = 1'b1;
        adv();
        load(7); adv();
        load(3);
        for (int k = 3; k <= 10; k++) begin
            if (k == 7) load(5);
            adv();
            checks++;
            if (bus.tick_out !== (k == 4 || k == 7 || k == 10) || bus.load_pending !== (k == 3 || (k >= 7 && k < 10)) ||
                bus.div_active !== (k < 4 ? 4 : k < 10 ? 3 : 5)) begin
                failures++;
                $display("FAIL back_to_back k=%0d tick=%b pend=%b act=%0d expected tick=%b pend=%b act=%0d",
                         k, bus.tick_out, bus.load_pending, bus.div_active, k == 4 || k == 7 || k == 10,
                         k == 3 || (k >= 7 && k < 10), k < 4 ? 4 : k < 10 ? 3 : 5);
            end
        end
    endtask

    task automatic test_min();
        test_reset();
        bus.ena = 1'b1;
        load(2);
        for (int k = 1; k <= 12; k++) begin
            adv();
            checks++;
            if (bus.tick_out !== (k >= 4 && k % 2 == 0) || bus.clk_out !== (k >= 4 && ((k - 4) / 2) % 2 == 0)) begin
                failures++;
                $display("FAIL min k=%0d tick=%b clk=%b expected tick=%b clk=%b", k, bus.tick_out, bus.clk_out,
                         k >= 4 && k % 2 == 0, k >= 4 && ((k - 4) / 2) % 2 == 0);
            end
        end
    endtask

`ifdef PHASE_SYNC_EN
    task automatic test_sync();
        test_reset();
        bus.ena = 1'b1;
        load(5); adv();
        adv();
        bus.sync = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            adv();
            checks++;
            if (bus.tick_out !== (k == 8) || bus.clk_out !== (k == 8) || bus.div_active !== 5 || bus.load_pending !== 1'b0) begin
                failures++;
                $display("FAIL sync k=%0d tick=%b clk=%b act=%0d pend=%b expected tick=%b clk=%b act=5 pend=0",
                         k, bus.tick_out, bus.clk_out, bus.div_active, bus.load_pending, k == 8, k == 8);
            end
        end
    endtask
`endif

    task automatic test_random();
        test_reset();
        for (int n = 0; n < 3000; n++) begin
            res = ($urandom % 100) != 0;
            bus.ena = ($urandom % 10) != 0;
            bus.div_load = ($urandom % 8) == 0;
            bus.div_in = W'($urandom % 10);
`ifdef PHASE_SYNC_EN
            bus.sync = ($urandom % 40) == 0;
`endif
            adv();
            checks++;
            if (bus.tick_out !== m_tick || bus.clk_out !== (m_per % 2 == 1) || bus.div_active !== m_act ||
                bus.load_pending !== m_pend || bus.div_err !== m_err) begin
                failures++;
                $display("FAIL random n=%0d tick=%b clk=%b act=%0d pend=%b err=%b expected tick=%b clk=%b act=%0d pend=%b err=%b",
                         n, bus.tick_out, bus.clk_out, bus.div_active, bus.load_pending, bus.div_err,
                         m_tick, m_per % 2 == 1, m_act, m_pend, m_err);
            end
        end
        res = 1'b1;
    endtask

    initial begin
        bus.ena = 1'b0;
        bus.div_in = '0;
        bus.div_load = 1'b0;
`ifdef PHASE_SYNC_EN
        bus.sync = 1'b0;
`endif
        test_reset();
        test_basic();
        test_load();
        test_invalid();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        test_min();
`ifdef PHASE_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
